// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one OTTER ALU between two requesters.
// One operation in flight: accept in IDLE, evaluate in EXEC, hand back in RESP.
module alu_share_arbiter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             P0_VALID,
    input  logic             P1_VALID,
    output logic             P0_READY,
    output logic             P1_READY,
    input  logic [31:0]      P0_SRCA,
    input  logic [31:0]      P0_SRCB,
    input  logic [31:0]      P1_SRCA,
    input  logic [31:0]      P1_SRCB,
    input  logic [3:0]       P0_FUN,
    input  logic [3:0]       P1_FUN,
    output logic [1:0]       RSP_VALID,
    input  logic [1:0]       RSP_READY,
    output logic [31:0]      RSP_RESULT,
    output logic             BUSY,
    output logic [CNT_W-1:0] OP_COUNT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        owner;
    logic        prio;
    logic        grant;
    logic        accept;
    logic        rsp_done;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  op_fun;
    logic [31:0] alu_out;

    // Grant follows prio only when both ports compete.
    always_comb begin
        grant = 1'b0;
        if (P0_VALID && P1_VALID) begin
            grant = prio;
        end else if (P1_VALID) begin
            grant = 1'b1;
        end
    end

    assign accept   = (state == IDLE) && (P0_VALID || P1_VALID);
    assign rsp_done = (state == RESP) && RSP_READY[owner];

    always_comb begin
        alu_out = '1;
        case (op_fun)
            4'b0000: alu_out = op_a + op_b;
            4'b1000: alu_out = op_a - op_b;
            4'b0110: alu_out = op_a | op_b;
            4'b0111: alu_out = op_a & op_b;
            4'b0100: alu_out = op_a ^ op_b;
            4'b0101: alu_out = op_a >> op_b[4:0];
            4'b0001: alu_out = op_a << op_b[4:0];
            4'b1101: alu_out = $signed(op_a) >>> op_b[4:0];
            4'b0010: alu_out = {31'd0, $signed(op_a) < $signed(op_b)};
            4'b0011: alu_out = {31'd0, op_a < op_b};
            4'b1001: alu_out = op_a;
            default: alu_out = '1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        P0_READY  = (state == IDLE) && !grant && P0_VALID;
        P1_READY  = (state == IDLE) && grant && P1_VALID;
        BUSY      = (state != IDLE);
        RSP_VALID = '0;
        if (state == RESP) begin
            RSP_VALID[owner] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            owner      <= 1'b0;
            prio       <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_fun     <= '0;
            RSP_RESULT <= '0;
            OP_COUNT   <= '0;
        end else begin
            if (accept) begin
                owner  <= grant;
                op_a   <= grant ? P1_SRCA : P0_SRCA;
                op_b   <= grant ? P1_SRCB : P0_SRCB;
                op_fun <= grant ? P1_FUN  : P0_FUN;
            end
            if (state == EXEC) begin
                RSP_RESULT <= alu_out;
            end
            if (rsp_done) begin
                prio <= ~owner;
                if (OP_COUNT != '1) begin
                    OP_COUNT <= OP_COUNT + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequences the OTTER ALU and shares one instance between two independent requesters (e.g. the main pipeline's execute stage and a multi-cycle helper unit). Each requester submits operands and an `alu_fun` code through a valid/ready handshake. The block arbitrates round-robin, registers the operands, evaluates them in the ALU, and returns a registered result on a shared result bus with a per-requester valid/ready handshake. One operation is in flight at a time.

## Interface
Parameters:
- `CNT_W`, 16, width of the saturating completed-operation counter.

Ports:
- `CLK`  in  1  single clock; all state updates on rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `P0_VALID`, `P1_VALID`  in  1 each  request valid for port 0 / port 1.
- `P0_READY`, `P1_READY`  out  1 each  request accepted this cycle.
- `P0_SRCA`, `P0_SRCB`, `P1_SRCA`, `P1_SRCB`  in  32 each  operands.
- `P0_FUN`, `P1_FUN`  in  4 each  ALU function code, using the standard OTTER ALU encoding.
- `RSP_VALID`  out  2  bit n: result for port n is valid.
- `RSP_READY`  in  2  bit n: port n consumes the result.
- `RSP_RESULT`  out  32  shared result bus.
- `BUSY`  out  1  high whenever state ≠ IDLE.
- `OP_COUNT`  out  CNT_W  completed operations; saturates at all-ones.

## Operation
- FSM states: IDLE, EXEC, RESP.
- Registered state: `owner` (1 bit), `prio` (1 bit, preferred port), operand regs A/B/FUN, `RSP_RESULT`, `OP_COUNT`.
- IDLE:
  - Grant = the only valid port, or `prio` if both ports are valid.
  - Grant logic is combinational. `Pn_READY` = (state == IDLE) & grant == n & `Pn_VALID`.
  - On accept: latch the granted port's SRCA, SRCB and FUN, set `owner` = granted port, go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC:
  - The ALU evaluates the latched operands.
  - Its output is registered into `RSP_RESULT`; go to RESP.
- RESP:
  - `RSP_VALID[owner]` = 1; the other bit stays 0. `RSP_RESULT` is held stable.
  - When `RSP_READY[owner]` is high: go to IDLE, set `prio` = ~owner, increment `OP_COUNT` unless it is all-ones.
- ALU semantics are the OTTER set:
  - ADD 0000, SUB 1000, OR 0110, AND 0111, XOR 0100.
  - SRL 0101, SLL 0001, SRA 1101. Shifts use `srcB[4:0]` only.
  - SLT 0010 (signed), SLTU 0011, LUI-copy 1001 (result = A).
  - Any other code gives 0xFFFFFFFF. This is not an error; it is passed through.
- `RSP_READY[~owner]` is ignored.
- `Pn_READY` is never asserted outside IDLE.
- Requester rule: hold VALID and operands stable until READY. Dropping VALID before grant is legal and leaves no side effect.

## Timing
- Reset values (asynchronous, on `RST_N` low): state = IDLE, `prio` = 0, `owner` = 0, operand regs = 0, `RSP_RESULT` = 0, `RSP_VALID` = 00, `BUSY` = 0, `OP_COUNT` = 0, `P0_READY` = `P1_READY` = 0.
- Reset mid-operation: the in-flight op is discarded with no response. The first accept is possible in the first cycle after `RST_N` deasserts.
- Latency: accept in cycle N; `RSP_VALID` rises in N+2.
- If `RSP_READY` is already high in N+2, the handshake completes in N+2. IDLE is in N+3, where the next accept can occur.
- Minimum spacing between accepts is 3 cycles.
- `BUSY` is high from N+1 until the cycle the FSM returns to IDLE.
- `OP_COUNT` updates on the clock edge that closes the response handshake.
- Simultaneous requests in IDLE: only one port is accepted. The loser's READY stays 0 and it is served at the next IDLE, provided it is still valid.
- A new request arriving during EXEC/RESP waits; there is no queueing beyond the requester holding VALID.

## Test plan
- Single op: reset, then P0 ADD 5+7 accepted in cycle N → `RSP_VALID` = 01 in N+2, `RSP_RESULT` = 12. With `RSP_READY` = 01, `OP_COUNT` = 1 and `BUSY` = 0 in N+3.
- Contention and fairness: after reset, both valid with P0 ADD 1+1 and P1 SUB 10-3.
  - Expect P0 accepted first, result 2.
  - Then P1 accepted at the next IDLE, result 7.
  - Repeat both valid: P0 is granted again, since `prio` = 0 after P1 completes.
- Backpressure: P1 XOR 0xFF00FF00 ^ 0x0F0F0F0F with `RSP_READY` = 00 for 5 cycles.
  - `RSP_VALID` = 10 and result 0xF00FF00F are held.
  - `P0_READY` stays 0 despite `P0_VALID` = 1.
  - `RSP_READY[0]` = 1 pulses are ignored.
- ALU edges:
  - SRA 0x80000000 by 0x24 gives 0xF8000000 (shift uses 4).
  - SLT -1 < 1 gives 1; SLTU 0xFFFFFFFF < 1 gives 0.
  - LUI-copy gives A.
  - FUN 1111 gives 0xFFFFFFFF.
- Reset mid-op: assert `RST_N` low during EXEC, then during RESP.
  - All outputs return to reset values immediately.
  - No response is issued after release.
  - A fresh P1 request is accepted in the first cycle after release.
- Counter saturation: with `CNT_W` = 4, run 17 ops; `OP_COUNT` stops at 15.
